// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared types and constants for the SPI master
// Contents: SPI_WIDTH (bits per transfer), BIT_CNT_W (falling-edge counter
// width, holds 0..SPI_WIDTH), state_t (IDLE, SETUP, XFER, HOLD).
package spi_pkg;

    localparam int SPI_WIDTH = 8;
    localparam int BIT_CNT_W = $clog2(SPI_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        XFER  = 2'd2,
        HOLD  = 2'd3
    } state_t;

endpackage

// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - host handshake and SPI pin bundle
// Signals: start/din (host request), dout/busy/done (host status),
// sck/ss/mosi (SPI outputs), miso (SPI input).
// Modports: slave = the SPI master block itself, master = host/driver side.
interface spi_master_if;
    import spi_pkg::*;

    logic                 start;
    logic [SPI_WIDTH-1:0] din;
    logic [SPI_WIDTH-1:0] dout;
    logic                 busy;
    logic                 done;
    logic                 sck;
    logic                 ss;
    logic                 mosi;
    logic                 miso;

    modport slave (
        input  start, din, miso,
        output dout, busy, done, sck, ss, mosi
    );

    modport master (
        output start, din, miso,
        input  dout, busy, done, sck, ss, mosi
    );

endinterface

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - sck half-period tick generator
// Ports: clk, rst (sync, active-high), en (count enable),
// tick (one-cycle pulse every CLK_DIV enabled cycles).
module spi_clk_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int                CNT_W  = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0]  RELOAD = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Disabled means parked at the reload value, so the first enabled cycle
    // starts a full half-period. Every tick reloads, which lines the reload
    // up with each sck transition and each state change of the master.
    always_comb begin
        tick  = 1'b0;
        cnt_d = cnt_q;
        if (!en) begin
            cnt_d = RELOAD;
        end else if (cnt_q == '0) begin
            tick  = 1'b1;
            cnt_d = RELOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 master, one SPI_WIDTH-bit transfer per start
// Ports: clk, rst (sync, active-high), bus (spi_master_if.slave):
// start/din in, dout/busy/done out, sck/ss/mosi out, miso in.
// Transfer timeline: SETUP (CLK_DIV), XFER (16*CLK_DIV), HOLD (CLK_DIV),
// then done in the first IDLE cycle.
module spi_master import spi_pkg::*; #(
    parameter int CLK_DIV = 4
) (
    input  logic         clk,
    input  logic         rst,
    spi_master_if.slave  bus
);

    localparam logic [BIT_CNT_W-1:0] LAST_FALL = BIT_CNT_W'(SPI_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0] ALL_FALLS = BIT_CNT_W'(SPI_WIDTH);

    state_t                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SPI_WIDTH-1:0]   tx_q, tx_d;
    logic [SPI_WIDTH-1:0]   rx_q, rx_d;
    logic [SPI_WIDTH-1:0]   dout_q, dout_d;
    logic                   sck_q, sck_d;
    logic                   ss_q, ss_d;
    logic                   mosi_q, mosi_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   tick;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q != IDLE),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        dout_d    = dout_q;
        sck_d     = sck_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                // Only IDLE looks at start, so start is ignored while busy.
                if (bus.start) begin
                    tx_d      = bus.din;
                    mosi_d    = bus.din[SPI_WIDTH-1];
                    rx_d      = '0;
                    bit_cnt_d = '0;
                    state_d   = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = XFER;
                    sck_d   = 1'b1;
                    rx_d    = {rx_q[SPI_WIDTH-2:0], bus.miso};
                end
            end
            XFER: begin
                if (tick) begin
                    if (sck_q) begin
                        // Falling edge: advance mosi except after the last bit.
                        sck_d     = 1'b0;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q != LAST_FALL) begin
                            tx_d   = tx_q << 1;
                            mosi_d = tx_q[SPI_WIDTH-2];
                        end
                    end else if (bit_cnt_q == ALL_FALLS) begin
                        // Last low phase has run its full length.
                        state_d = HOLD;
                    end else begin
                        sck_d = 1'b1;
                        rx_d  = {rx_q[SPI_WIDTH-2:0], bus.miso};
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    dout_d  = rx_q;
                    mosi_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Registered outputs follow the next state so they change together
        // with it.
        ss_d   = (state_d == IDLE);
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            tx_q      <= '0;
            rx_q      <= '0;
            dout_q    <= '0;
            sck_q     <= 1'b0;
            ss_q      <= 1'b1;
            mosi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            dout_q    <= dout_d;
            sck_q     <= sck_d;
            ss_q      <= ss_d;
            mosi_q    <= mosi_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.dout = dout_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sck  = sck_q;
    assign bus.ss   = ss_q;
    assign bus.mosi = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// tb/tb_spi_master.sv - directed self-checking bench for spi_master
module tb_spi_master;
    import spi_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spi_master_if b4 ();
    spi_master_if b2 ();

    spi_master #(.CLK_DIV(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
    spi_master #(.CLK_DIV(2)) u_dut2 (.clk(clk), .rst(rst), .bus(b2.slave));

    // sel picks which instance the stimulus and observation point at.
    logic       sel;
    logic       start_v;
    logic       loop_v;
    logic       miso_v;
    logic [7:0] din_v;

    assign b4.start = !sel && start_v;
    assign b2.start =  sel && start_v;
    assign b4.din   = din_v;
    assign b2.din   = din_v;
    assign b4.miso  = loop_v ? b4.mosi : miso_v;
    assign b2.miso  = loop_v ? b2.mosi : miso_v;

    logic       m_sck, m_ss, m_mosi, m_busy, m_done;
    logic [7:0] m_dout;
    assign m_sck  = sel ? b2.sck  : b4.sck;
    assign m_ss   = sel ? b2.ss   : b4.ss;
    assign m_mosi = sel ? b2.mosi : b4.mosi;
    assign m_busy = sel ? b2.busy : b4.busy;
    assign m_done = sel ? b2.done : b4.done;
    assign m_dout = sel ? b2.dout : b4.dout;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Results of the last run_xfer call.
    int         r_lat, r_rises, r_ssl, r_phase_bad, r_extra;
    logic [7:0] r_caps, r_dout_done, r_dout_end;
    logic       r_ss_done, r_busy_done;

    // Pulse start for one cycle, then watch 1+18*cdiv+tail cycles.
    task automatic run_xfer(input logic [7:0] d, input int restart_at, input int cdiv, input int tail);
        int   run;
        logic prev;
        r_lat = -1; r_rises = 0; r_ssl = 0; r_phase_bad = 0; r_extra = 0;
        r_caps = 8'h00; r_dout_done = 8'h00; r_ss_done = 1'b0; r_busy_done = 1'b1;
        start_v = 1'b1;
        din_v   = d;
        @(posedge clk); #1;
        start_v = 1'b0;
        prev = 1'b0;
        run  = 0;
        for (int i = 1; i <= 1 + 18 * cdiv + tail; i++) begin
            if (m_sck != prev) begin
                if (m_sck) begin
                    r_rises++;
                    r_caps = {r_caps[6:0], m_mosi};
                    if (r_rises > 1 && run != cdiv) r_phase_bad++;
                end else if (run != cdiv) begin
                    r_phase_bad++;
                end
                run = 1;
            end else begin
                run++;
            end
            prev = m_sck;
            if (!m_ss) r_ssl++;
            if (m_done) begin
                if (r_lat < 0) begin
                    r_lat       = i;
                    r_ss_done   = m_ss;
                    r_busy_done = m_busy;
                    r_dout_done = m_dout;
                end else begin
                    r_extra++;
                end
            end
            if (i == restart_at) begin
                start_v = 1'b1;
                din_v   = 8'h00;
            end else if (i == restart_at + 1) begin
                start_v = 1'b0;
            end
            @(posedge clk); #1;
        end
        r_dout_end = m_dout;
    endtask

    int         d1, d2, ss_hi, n_done, n_rise;
    logic [7:0] dout1, dout2;
    logic       prev_sck;

    initial begin
        rst = 1'b1; sel = 1'b0; start_v = 1'b0; loop_v = 1'b1; miso_v = 1'b0; din_v = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check("rst_ss",   32'(m_ss),   32'd1);
        check("rst_sck",  32'(m_sck),  32'd0);
        check("rst_mosi", 32'(m_mosi), 32'd0);
        check("rst_busy", 32'(m_busy), 32'd0);
        check("rst_done", 32'(m_done), 32'd0);
        check("rst_dout", 32'(m_dout), 32'h00);
        repeat (2) @(posedge clk);
        #1;

        // Loopback A5, CLK_DIV=4
        run_xfer(8'hA5, 0, 4, 10);
        check("a5_latency",   32'(r_lat),       32'd73);
        check("a5_dout",      32'(r_dout_done), 32'hA5);
        check("a5_rises",     32'(r_rises),     32'd8);
        check("a5_ss_low",    32'(r_ssl),       32'd72);
        check("a5_ss_done",   32'(r_ss_done),   32'd1);
        check("a5_busy_done", 32'(r_busy_done), 32'd0);
        check("a5_single",    32'(r_extra),     32'd0);
        check("a5_phases",    32'(r_phase_bad), 32'd0);
        check("a5_caps",      32'(r_caps),      32'hA5);
        check("a5_dout_hold", 32'(r_dout_end),  32'hA5);
        check("idle_mosi",    32'(m_mosi),      32'd0);

        // miso held high, din 3C
        loop_v = 1'b0; miso_v = 1'b1;
        run_xfer(8'h3C, 0, 4, 10);
        check("ff_dout", 32'(r_dout_done), 32'hFF);
        check("ff_caps", 32'(r_caps),      32'h3C);
        check("ff_lat",  32'(r_lat),       32'd73);
        loop_v = 1'b1; miso_v = 1'b0;

        // start while busy is ignored
        run_xfer(8'hC3, 10, 4, 80);
        check("busy_lat",    32'(r_lat),       32'd73);
        check("busy_single", 32'(r_extra),     32'd0);
        check("busy_dout",   32'(r_dout_done), 32'hC3);
        check("busy_rises",  32'(r_rises),     32'd8);

        // Back-to-back with start held high
        din_v = 8'h12; start_v = 1'b1; d1 = -1; d2 = -1; ss_hi = 0;
        dout1 = 8'h00; dout2 = 8'h00;
        for (int i = 1; i <= 200 && d2 < 0; i++) begin
            @(posedge clk); #1;
            if (m_done) begin
                if (d1 < 0) begin
                    d1 = i; dout1 = m_dout; din_v = 8'h34;
                end else begin
                    d2 = i; dout2 = m_dout;
                end
            end
            if (d1 >= 0 && d2 < 0 && m_ss) ss_hi++;
            if (d1 >= 0 && i == d1 + 1) start_v = 1'b0;
        end
        start_v = 1'b0;
        check("b2b_first_lat", 32'(d1),      32'd73);
        check("b2b_gap",       32'(d2 - d1), 32'd73);
        check("b2b_ss_high",   32'(ss_hi),   32'd1);
        check("b2b_dout1",     32'(dout1),   32'h12);
        check("b2b_dout2",     32'(dout2),   32'h34);
        repeat (3) @(posedge clk);
        #1;

        // Reset 40 cycles into a transfer
        din_v = 8'hF0; start_v = 1'b1;
        @(posedge clk); #1;
        start_v = 1'b0;
        repeat (39) @(posedge clk);
        #1;
        check("mid_busy_before", 32'(m_busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_ss",   32'(m_ss),   32'd1);
        check("abort_sck",  32'(m_sck),  32'd0);
        check("abort_busy", 32'(m_busy), 32'd0);
        check("abort_dout", 32'(m_dout), 32'h00);
        n_done = 0; n_rise = 0; prev_sck = m_sck;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            if (m_done) n_done++;
            if (m_sck && !prev_sck) n_rise++;
            prev_sck = m_sck;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        check("abort_no_sck",  32'(n_rise), 32'd0);

        // rst wins over start in the same cycle
        rst = 1'b1; start_v = 1'b1; din_v = 8'hFF;
        @(posedge clk); #1;
        rst = 1'b0; start_v = 1'b0;
        check("prio_busy", 32'(m_busy), 32'd0);
        check("prio_ss",   32'(m_ss),   32'd1);
        repeat (2) @(posedge clk);
        #1;

        // CLK_DIV=2 loopback 81
        sel = 1'b1;
        run_xfer(8'h81, 0, 2, 10);
        check("d2_latency", 32'(r_lat),       32'd37);
        check("d2_dout",    32'(r_dout_done), 32'h81);
        check("d2_rises",   32'(r_rises),     32'd8);
        check("d2_phases",  32'(r_phase_bad), 32'd0);
        check("d2_ss_low",  32'(r_ssl),       32'd36);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
